// File: rtl/rf_write_scheduler.sv
// Register file write-port scheduler: round-robin between ALU and load
// results, registered write strobe, and a busy scoreboard for issue hazards.
module rf_write_scheduler #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_rd,
   output logic            iss_stall,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic            hz1,
   output logic            hz2,
   input  logic            alu_valid,
   input  logic [AW-1:0]   alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            mem_valid,
   input  logic [AW-1:0]   mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            mem_ready,
   output logic            rf_we,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            idle
);

   typedef enum logic {
      PICK_ALU = 1'b0,
      PICK_MEM = 1'b1
   } side_t;

   localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

   side_t            rr_ptr;
   side_t            rr_next;
   logic             grant_alu;
   logic             grant_mem;
   logic             conflict;
   logic [AW-1:0]    win_rd;
   logic [XLEN-1:0]  win_data;
   logic             win_live;

   logic [NREG-1:0]  busy;
   logic [NREG-1:0]  busy_next;
   logic [NREG-1:0]  set_vec;
   logic [NREG-1:0]  clr_vec;
   logic             issue_ok;
   logic             waw;

   // Arbitration: a lone requester always wins; on conflict rr_ptr decides.
   always_comb begin
      conflict  = alu_valid & mem_valid;
      grant_alu = 1'b0;
      grant_mem = 1'b0;
      rr_next   = rr_ptr;
      if (conflict) begin
         grant_alu = (rr_ptr == PICK_ALU);
         grant_mem = (rr_ptr == PICK_MEM);
         rr_next   = (rr_ptr == PICK_ALU) ? PICK_MEM : PICK_ALU;
      end else begin
         grant_alu = alu_valid;
         grant_mem = mem_valid;
      end
   end

   assign alu_ready = grant_alu;
   assign mem_ready = grant_mem;

   always_comb begin
      win_rd   = '0;
      win_data = '0;
      if (grant_alu) begin
         win_rd   = alu_rd;
         win_data = alu_data;
      end else if (grant_mem) begin
         win_rd   = mem_rd;
         win_data = mem_data;
      end
   end

   // x0 results are consumed but never reach the register file.
   assign win_live = (grant_alu | grant_mem) & (win_rd != '0);

   // Hazard detection against the current scoreboard only; no forwarding.
   always_comb begin
      hz1       = busy[rs1] & (rs1 != '0);
      hz2       = busy[rs2] & (rs2 != '0);
      waw       = busy[iss_rd];
      iss_stall = iss_valid & (hz1 | hz2 | waw);
      issue_ok  = iss_valid & ~iss_stall & (iss_rd != '0);
   end

   // Set is applied after clear so a new producer outlives a retiring one.
   always_comb begin
      set_vec   = issue_ok ? (ONE_HOT0 << iss_rd) : '0;
      clr_vec   = rf_we ? (ONE_HOT0 << rf_waddr) : '0;
      busy_next = (busy & ~clr_vec) | set_vec;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= PICK_MEM;
         busy   <= '0;
      end else begin
         rr_ptr <= rr_next;
         busy   <= busy_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= win_live;
         if (win_live) begin
            rf_waddr <= win_rd;
            rf_wdata <= win_data;
         end
      end
   end

   assign idle = (busy == '0) & ~rf_we;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed scenarios plus randomized traffic
// checked every cycle against a per-register reference model.
module tb_rf_write_scheduler;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            iss_valid;
   logic [AW-1:0]   iss_rd;
   logic            iss_stall;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic            hz1;
   logic            hz2;
   logic            alu_valid;
   logic [AW-1:0]   alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            alu_ready;
   logic            mem_valid;
   logic [AW-1:0]   mem_rd;
   logic [XLEN-1:0] mem_data;
   logic            mem_ready;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            idle;

   rf_write_scheduler #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall),
      .rs1(rs1), .rs2(rs2), .hz1(hz1), .hz2(hz2),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .mem_ready(mem_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .idle(idle)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference state: which registers await a write, who wins the next
   // tie, and what the register file is being told this cycle.
   bit              m_busy[NREG];
   bit              m_mem_first;
   bit              m_we;
   logic [AW-1:0]   m_waddr;
   logic [XLEN-1:0] m_wdata;
   bit              m_ga;
   bit              m_gm;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_all_clear();
      foreach (m_busy[i]) if (m_busy[i]) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: check outputs against the model, then advance the model
   // across the rising edge using the same inputs the DUT saw.
   task automatic step();
      bit e_hz1, e_hz2, e_stall, take, issue;
      logic [AW-1:0]   w_rd;
      logic [XLEN-1:0] w_data;
      #1;
      if (alu_valid && mem_valid) begin
         m_ga = !m_mem_first;
         m_gm = m_mem_first;
      end else begin
         m_ga = alu_valid;
         m_gm = mem_valid;
      end
      e_hz1   = m_busy[rs1] && rs1 != 0;
      e_hz2   = m_busy[rs2] && rs2 != 0;
      e_stall = iss_valid && (e_hz1 || e_hz2 || m_busy[iss_rd]);
      check("alu_ready", alu_ready, m_ga);
      check("mem_ready", mem_ready, m_gm);
      check("hz1", hz1, e_hz1);
      check("hz2", hz2, e_hz2);
      check("iss_stall", iss_stall, e_stall);
      check("rf_we", rf_we, m_we);
      check("rf_waddr", rf_waddr, m_waddr);
      check("rf_wdata", rf_wdata, m_wdata);
      check("idle", idle, m_all_clear() && !m_we);
      @(posedge clk);
      if (rst) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_mem_first = 1'b1;
         m_we = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
      end else begin
         if (alu_valid && mem_valid) m_mem_first = !m_mem_first;
         take   = m_ga || m_gm;
         w_rd   = m_ga ? alu_rd : mem_rd;
         w_data = m_ga ? alu_data : mem_data;
         issue  = iss_valid && !e_stall && iss_rd != 0;
         if (m_we) m_busy[m_waddr] = 1'b0;
         if (issue) m_busy[iss_rd] = 1'b1;
         if (take && w_rd != 0) begin
            m_we = 1'b1;
            m_waddr = w_rd;
            m_wdata = w_data;
         end else begin
            m_we = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic quiet();
      iss_valid = 0; iss_rd = '0; rs1 = '0; rs2 = '0;
      alu_valid = 0; alu_rd = '0; alu_data = '0;
      mem_valid = 0; mem_rd = '0; mem_data = '0;
   endtask

   logic [AW-1:0] seq_exp[4];

   initial begin
      quiet();
      rst = 1;
      m_mem_first = 1;
      m_we = 0;
      m_waddr = '0;
      m_wdata = '0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      @(negedge clk);
      step();
      step();
      rst = 0;

      // Idle after reset, readies follow valids.
      #1;
      check("rst_idle", idle, 1'b1);
      check("rst_we", rf_we, 1'b0);
      step();
      mem_valid = 1; mem_rd = 0;
      #1;
      check("rst_mem_rdy", mem_ready, 1'b1);
      step();
      quiet();

      // Single ALU write.
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      #1;
      check("alu1_ready", alu_ready, 1'b1);
      step();
      quiet();
      check("alu1_we", rf_we, 1'b1);
      check("alu1_addr", rf_waddr, 5);
      check("alu1_data", rf_wdata, 32'hDEADBEEF);
      step();
      check("alu1_we_off", rf_we, 1'b0);

      // Round-robin conflict, mem first.
      seq_exp[0] = 7; seq_exp[1] = 3; seq_exp[2] = 7; seq_exp[3] = 3;
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1; alu_rd = 3; alu_data = 32'hA000 + i;
         mem_valid = 1; mem_rd = 7; mem_data = 32'hB000 + i;
         step();
         check("rr_addr", rf_waddr, seq_exp[i]);
      end
      quiet();
      step();
      step();

      // RAW hazard on x9 until the load write retires.
      iss_valid = 1; iss_rd = 9;
      step();
      iss_rd = 10; rs1 = 9;
      #1;
      check("raw_hz1", hz1, 1'b1);
      check("raw_stall", iss_stall, 1'b1);
      step();
      iss_valid = 0;
      mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
      step();
      mem_valid = 0;
      step();
      #1;
      check("raw_clear", hz1, 1'b0);
      step();
      quiet();

      // x0 results are consumed silently.
      alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
      #1;
      check("x0_ready", alu_ready, 1'b1);
      step();
      quiet();
      check("x0_we", rf_we, 1'b0);
      check("x0_idle", idle, 1'b1);

      // Retiring write and new issue collide on x4: set wins.
      mem_valid = 1; mem_rd = 4; mem_data = 32'h44;
      step();
      quiet();
      iss_valid = 1; iss_rd = 4;
      #1;
      check("col_we", rf_we, 1'b1);
      check("col_nostall", iss_stall, 1'b0);
      step();
      quiet();
      rs1 = 4;
      #1;
      check("col_busy", hz1, 1'b1);
      step();

      // Reset while a write is in flight.
      mem_valid = 1; mem_rd = 6; mem_data = 32'h66;
      step();
      quiet();
      rst = 1;
      step();
      rst = 0;
      rs1 = 4;
      #1;
      check("rst_mid_we", rf_we, 1'b0);
      check("rst_mid_busy", hz1, 1'b0);
      step();

      // Randomized traffic; requesters hold their offer until accepted.
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(299) == 0);
         if (!(alu_valid && !m_ga) || rst) begin
            alu_valid = $urandom_range(1);
            alu_rd    = AW'($urandom_range(7));
            alu_data  = $urandom;
         end
         if (!(mem_valid && !m_gm) || rst) begin
            mem_valid = $urandom_range(1);
            mem_rd    = AW'($urandom_range(7));
            mem_data  = $urandom;
         end
         iss_valid = ($urandom_range(2) == 0);
         iss_rd    = AW'($urandom_range(7));
         rs1       = AW'($urandom_range(7));
         rs2       = ($urandom_range(3) == 0) ? AW'($urandom) : AW'($urandom_range(7));
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Sequences the register file's single write port between two completion sources: the ALU result path and the load/writeback path.
- Round-robin arbitration, registered write strobe, x0 suppression.
- Per-register busy scoreboard for issue-stage RAW/WAW hazard detection.
- Sits between execute/memory stages and the 32-entry register file. Drives its write inputs; the register file's read ports are untouched.

Parameters:
- XLEN, 32, data width of write values.
- NREG, 32, number of architectural registers (x0 hardwired zero).
- AW, 5, register address width, log2(NREG).

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous active-high reset
- iss_valid  in  1  instruction issuing this cycle that will write iss_rd
- iss_rd  in  AW  destination of issuing instruction
- iss_stall  out  AW-indep 1  issue blocked (hazard on rs1/rs2/rd)
- rs1, rs2  in  AW  source registers of the instruction at issue
- hz1, hz2  out  1  source register has a pending write
- alu_valid  in  1  ALU result offered
- alu_rd  in  AW  ALU destination
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- mem_valid  in  1  load/writeback result offered
- mem_rd  in  AW  load destination
- mem_data  in  XLEN  load result
- mem_ready  out  1  load result accepted this cycle
- rf_we  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  XLEN  register file write data
- idle  out  1  no busy bits set and no write in flight

Behaviour:
- Reset (rst=1 at rising clk): busy[] all 0; rf_we=0, rf_waddr=0, rf_wdata=0; rr_ptr=MEM (mem wins first conflict).
  - Reset overrides all same-cycle requests; an accepted-but-unwritten result is discarded.
- Arbitration, combinational from valids and rr_ptr:
  - Only one valid: it is granted.
  - Both valid: side selected by rr_ptr is granted.
  - alu_ready = grant_alu; mem_ready = grant_mem. At most one ready high per cycle.
  - A requester holds valid/rd/data stable until ready.
- rr_ptr update: flips to the other side only on a cycle where both were valid. Single-requester grants leave it unchanged.
- Write latency: a result accepted at edge N produces rf_we=1 with its rd/data during cycle N..N+1. The register file captures it at edge N+1. One write per cycle max; back-to-back acceptance gives back-to-back rf_we.
- x0 handling: rd=0 results are accepted (ready high) but rf_we stays 0 and no busy bit is touched.
- rf_waddr/rf_wdata hold their last values when rf_we=0.
- Scoreboard:
  - Set busy[iss_rd] at the edge where iss_valid=1, iss_stall=0, iss_rd!=0.
  - Clear busy[rf_waddr] at the edge ending an rf_we=1 cycle.
  - Set and clear on the same register at the same edge: set wins (newer producer).
- Hazards:
  - hz1 = busy[rs1] and rs1!=0; hz2 likewise.
  - iss_stall = iss_valid and (hz1 or hz2 or busy[iss_rd]). Stalls WAW as well; no forwarding.
- idle = (busy all zero) and rf_we=0.
- A result arriving for a register whose busy bit is clear is still written; the bit stays 0. No error is flagged.

Test Plan:
- Reset then idle: rst 2 cycles -> rf_we=0, idle=1, hz1=hz2=0, both ready follow valid.
- Single ALU write: alu_valid rd=5 data=0xDEADBEEF at edge N -> alu_ready=1 in cycle before N; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF during N..N+1; rf_we=0 next.
- Conflict round-robin: alu and mem both valid for 4 cycles, rd=3/7 -> grant order mem, alu, mem, alu; rf_waddr sequence 7,3,7,3.
- Scoreboard RAW: issue rd=9 -> next cycle rs1=9 gives hz1=1, iss_stall=1 when iss_valid. After mem write rd=9 completes, hz1=0.
- x0 suppression: alu_valid rd=0 data=0x1234 -> alu_ready=1, rf_we stays 0, idle unaffected.
- Set/clear collision plus reset mid-op:
  - Write to rd=4 commits on the same edge a new issue sets rd=4 -> busy[4]=1 afterwards.
  - Assert rst while a write is pending -> rf_we=0 and busy cleared the next cycle.
